// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// counter sizing helper.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(n)), never less than 1, so a counter can hold 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, result published
// in full only when the last bit has been processed.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_diff;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign res_next = {cell_diff, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // At the last bit, borrow still holds the borrow into the MSB,
    // which together with the cell's borrow out gives the overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= res_next;
            borrow <= cell_bout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                diff <= res_next;
                bout <= cell_bout;
                ovf  <= borrow ^ cell_bout;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 2, 8 and 16 against an
// integer-arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        s2_start, s2_bin, s2_bout, s2_ovf, s2_busy, s2_done;
    logic [1:0]  s2_a, s2_b, s2_diff;
    logic        s8_start, s8_bin, s8_bout, s8_ovf, s8_busy, s8_done;
    logic [7:0]  s8_a, s8_b, s8_diff;
    logic        s16_start, s16_bin, s16_bout, s16_ovf, s16_busy, s16_done;
    logic [15:0] s16_a, s16_b, s16_diff;

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .a(s2_a), .b(s2_b), .bin(s2_bin),
        .diff(s2_diff), .bout(s2_bout), .ovf(s2_ovf), .busy(s2_busy), .done(s2_done)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .bin(s8_bin),
        .diff(s8_diff), .bout(s8_bout), .ovf(s8_ovf), .busy(s8_busy), .done(s8_done)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .a(s16_a), .b(s16_b), .bin(s16_bin),
        .diff(s16_diff), .bout(s16_bout), .ovf(s16_ovf), .busy(s16_busy), .done(s16_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic st, input logic [63:0] av,
                         input logic [63:0] bv, input logic bi);
        case (w)
            2: begin s2_start = st; s2_a = av[1:0]; s2_b = bv[1:0]; s2_bin = bi; end
            8: begin s8_start = st; s8_a = av[7:0]; s8_b = bv[7:0]; s8_bin = bi; end
            default: begin s16_start = st; s16_a = av[15:0]; s16_b = bv[15:0]; s16_bin = bi; end
        endcase
    endtask

    task automatic sample(input int w, output logic [63:0] d, output logic bo,
                          output logic ov, output logic bz, output logic dn);
        case (w)
            2: begin d = 64'(s2_diff); bo = s2_bout; ov = s2_ovf; bz = s2_busy; dn = s2_done; end
            8: begin d = 64'(s8_diff); bo = s8_bout; ov = s8_ovf; bz = s8_busy; dn = s8_done; end
            default: begin d = 64'(s16_diff); bo = s16_bout; ov = s16_ovf; bz = s16_busy; dn = s16_done; end
        endcase
    endtask

    // Reference: plain integer subtraction, unsigned underflow and signed range test.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, output logic [63:0] d, output logic bo,
                         output logic ov);
        longint m, half, ua, ub, r, sa, sb, sr;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(av) & (m - 1);
        ub   = longint'(bv) & (m - 1);
        r    = ua - ub - longint'(bi);
        bo   = (r < 0);
        d    = 64'((r < 0) ? r + m : r);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sr   = sa - sb - longint'(bi);
        ov   = (sr < -half) || (sr > half - 1);
    endtask

    task automatic rnd64(output logic [63:0] v);
        v = {$urandom, $urandom};
    endtask

    // One full operation with operands and start randomised while busy.
    task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                          input logic bi, input string tag);
        logic [63:0] ed, d, ra, rb;
        logic        ebo, eov, bo, ov, bz, dn;
        model(w, av, bv, bi, ed, ebo, eov);
        drive(w, 1'b1, av, bv, bi);
        for (int k = 0; k < w; k++) begin
            tick();
            rnd64(ra);
            rnd64(rb);
            drive(w, 1'($urandom), ra, rb, 1'($urandom));
            sample(w, d, bo, ov, bz, dn);
            check($sformatf("%s busy/done edge %0d", tag, k), {62'd0, bz, dn}, 64'b10);
        end
        drive(w, 1'b0, ra, rb, 1'b0);
        tick();
        sample(w, d, bo, ov, bz, dn);
        check($sformatf("%s busy/done at completion", tag), {62'd0, bz, dn}, 64'b01);
        check($sformatf("%s diff", tag), d, ed);
        check($sformatf("%s bout", tag), 64'(bo), 64'(ebo));
        check($sformatf("%s ovf", tag), 64'(ov), 64'(eov));
        tick();
        sample(w, d, bo, ov, bz, dn);
        check($sformatf("%s idle after done", tag), {62'd0, bz, dn}, 64'b00);
        check($sformatf("%s diff held", tag), d, ed);
    endtask

    initial begin
        logic [63:0] d, ed;
        logic        bo, ov, bz, dn, ebo, eov;
        logic [7:0]  qa [32];
        logic [7:0]  qb [32];
        logic        qbin [32];

        rst = 1'b1;
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(16, 1'b0, 64'd0, 64'd0, 1'b0);
        #12;
        sample(8, d, bo, ov, bz, dn);
        check("reset w8 outputs", {d[59:0], bo, ov, bz, dn}, 64'd0);
        sample(2, d, bo, ov, bz, dn);
        check("reset w2 outputs", {d[59:0], bo, ov, bz, dn}, 64'd0);
        sample(16, d, bo, ov, bz, dn);
        check("reset w16 outputs", {d[59:0], bo, ov, bz, dn}, 64'd0);
        #1 rst = 1'b0;

        // Start is offered before the first edge after reset release.
        run_op(8, 64'h05, 64'h03, 1'b0, "w8 05-03");
        check("w8 05-03 literal diff", 64'(s8_diff), 64'h02);
        run_op(8, 64'h00, 64'h01, 1'b0, "w8 00-01");
        check("w8 00-01 literal", {55'd0, s8_diff, s8_bout}, {55'd0, 8'hFF, 1'b1});
        run_op(8, 64'h80, 64'h01, 1'b0, "w8 80-01");
        check("w8 80-01 literal", {54'd0, s8_diff, s8_bout, s8_ovf}, {54'd0, 8'h7F, 1'b0, 1'b1});
        run_op(8, 64'h10, 64'h0F, 1'b1, "w8 10-0F-1");
        check("w8 10-0F-1 literal", {55'd0, s8_diff, s8_bout}, 64'd0);
        run_op(8, 64'h7F, 64'hFF, 1'b1, "w8 7F-FF-1");

        for (int i = 0; i < 40; i++) begin
            run_op(8, 64'($urandom), 64'($urandom), 1'($urandom), $sformatf("w8 rnd%0d", i));
        end

        // Start held high with operands changing every cycle.
        for (int k = 0; k < 28; k++) begin
            if (k < 20) begin
                qa[k] = 8'($urandom); qb[k] = 8'($urandom); qbin[k] = 1'($urandom);
                drive(8, 1'b1, 64'(qa[k]), 64'(qb[k]), qbin[k]);
            end else begin
                drive(8, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom));
            end
            tick();
            sample(8, d, bo, ov, bz, dn);
            if (k < 20) begin
                check($sformatf("held start busy/done k%0d", k), {62'd0, bz, dn},
                      (k % 9 == 8) ? 64'b01 : 64'b10);
            end else begin
                check($sformatf("held start tail busy/done k%0d", k), {62'd0, bz, dn},
                      (k == 26) ? 64'b01 : ((k < 26) ? 64'b10 : 64'b00));
            end
            if (k == 8 || k == 17 || k == 26) begin
                model(8, 64'(qa[k - 8]), 64'(qb[k - 8]), qbin[k - 8], ed, ebo, eov);
                check($sformatf("held start result k%0d", k), {d[61:0], bo, ov}, {ed[61:0], ebo, eov});
            end
        end

        // Asynchronous reset between edges while bit 4 is pending.
        run_op(8, 64'h37, 64'h12, 1'b0, "w8 pre-reset");
        drive(8, 1'b1, 64'h99, 64'h11, 1'b0);
        tick();
        drive(8, 1'b0, 64'h99, 64'h11, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        #2 rst = 1'b1;
        #1;
        sample(8, d, bo, ov, bz, dn);
        check("mid-run reset outputs", {d[59:0], bo, ov, bz, dn}, 64'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            sample(8, d, bo, ov, bz, dn);
            check($sformatf("post-reset quiet k%0d", k), {d[59:0], bo, ov, bz, dn}, 64'd0);
        end
        run_op(8, 64'h99, 64'h11, 1'b0, "w8 post-reset");

        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run_op(2, 64'(av), 64'(bv), 1'(bi), $sformatf("w2 %0d-%0d-%0d", av, bv, bi));
                end
            end
        end

        for (int i = 0; i < 1000; i++) begin
            run_op(16, 64'($urandom), 64'($urandom), 1'($urandom), $sformatf("w16 rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
